// File: rtl/adder_pkg.sv
// Shared definitions for the multi-word slice-serial adder.
//   state_t         : controller FSM states (IDLE, RUN, DONE)
//   DEF_DATA_W      : default operand / sum width
//   DEF_SLICE_W     : default width added per cycle by the shared slice adder
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SLICE_W = 8;

endpackage

// File: rtl/slice_adder.sv
// Combinational SLICE_W-bit adder slice with generate/propagate carry chain.
//   i_a, i_b : slice operands
//   i_cin    : carry into bit 0 of the slice
//   o_sum    : p ^ carry
//   o_cout   : carry out of the top bit of the slice
//   o_cmsb   : carry into the top bit of the slice (used for signed overflow)
module slice_adder #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout,
  output logic               o_cmsb
);

  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W:0]   w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Carry prefix over (g,p), seeded by the incoming carry.
  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < SLICE_W; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign o_sum  = w_p ^ w_c[SLICE_W-1:0];
  assign o_cout = w_c[SLICE_W];
  assign o_cmsb = w_c[SLICE_W-1];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Slice-serial DATA_W-bit adder: one shared SLICE_W-bit slice adder is reused
// for NSLICE = DATA_W/SLICE_W cycles, least-significant slice first.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, cin            : operands and carry-in, latched on accept
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, cout, ovf       : A+B+cin mod 2^DATA_W, carry-out, signed overflow
module multiword_add_ctrl
  import adder_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  if (SLICE_W <= 0 || DATA_W <= 0 || (DATA_W % SLICE_W) != 0) begin : g_bad_width
    $error("multiword_add_ctrl: DATA_W must be a nonzero multiple of SLICE_W");
  end

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SH_W   = $clog2(DATA_W) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NSLICE - 1);
  localparam logic [DATA_W-1:0] SLICE_MASK = DATA_W'({SLICE_W{1'b1}});

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [SH_W-1:0]    w_base;
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_s;
  logic               w_co;
  logic               w_cmsb;

  // Bit offset of the slice being processed this cycle.
  assign w_base = SH_W'(r_idx) * SH_W'(SLICE_W);
  assign w_a_sl = SLICE_W'(r_a >> w_base);
  assign w_b_sl = SLICE_W'(r_b >> w_base);
  assign w_last = (r_idx == LAST_IDX);

  slice_adder #(
    .SLICE_W (SLICE_W)
  ) u_slice_adder (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_co),
    .o_cmsb (w_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are pure data: captured on accept, never cleared.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_a <= a;
      r_b <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= (r_sum & ~(SLICE_MASK << w_base)) | (DATA_W'(w_s) << w_base);
      r_carry <= w_co;
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= w_cmsb ^ w_co;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter SLICE_W, default 8, giving the bits added per cycle by the shared slice adder; NSLICE = DATA_W/SLICE_W.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: the operand set on a, b and cin is valid.
REQ-006 Port in_ready, output, 1: the block can accept operands.
REQ-007 Port a, input, DATA_W: addend A.
REQ-008 Port b, input, DATA_W: addend B.
REQ-009 Port cin, input, 1: carry-in to bit 0.
REQ-010 Port out_valid, output, 1: sum, cout and ovf hold a valid result.
REQ-011 Port out_ready, input, 1: the consumer accepts the result.
REQ-012 Port sum, output, DATA_W: A+B+cin modulo 2^DATA_W.
REQ-013 Port cout, output, 1: carry out of bit DATA_W-1.
REQ-014 Port ovf, output, 1: signed overflow, equal to the carry into the MSB XOR cout.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready=1; in all other states in_ready=0.
REQ-017 An accept SHALL occur on an edge with in_valid=1 and in_ready=1; on it the block latches a, b and cin into the carry register, clears the slice index to 0 and enters RUN.
REQ-018 Each RUN cycle SHALL add slice idx as follows: p=a^b and g=a&b for bits [idx*SLICE_W +: SLICE_W], carries from the prefix of (g,p) seeded by the carry register, and sum bits = p^carry.
REQ-019 Each RUN edge SHALL write that slice's sum bits, load the slice carry-out into the carry register and increment idx.
REQ-020 When idx=NSLICE-1, the RUN edge SHALL store cout and ovf, return idx to 0 and enter DONE.
REQ-021 out_valid SHALL rise exactly NSLICE edges after the accept edge (4 for the defaults), and equals 1 only in DONE.
REQ-022 In DONE, sum, cout and ovf SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-023 out_valid=1 with out_ready=0 SHALL hold the result indefinitely (backpressure); no new operands are accepted meanwhile.
REQ-024 An accept SHALL never occur on the same edge as a DONE exit; the minimum issue interval is NSLICE+2 cycles.
REQ-025 Operand changes on a and b after the accept SHALL NOT affect the result.
REQ-026 Width rule: DATA_W SHALL be a nonzero multiple of SLICE_W; otherwise elaboration fails via an assertion.
REQ-027 Wrap-around: an all-ones operand plus 1 SHALL yield sum=0 and cout=1.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, idx=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0 and in_ready=1 on the following cycle.
REQ-029 A reset during RUN or DONE SHALL abandon the operation with no result emitted; reset takes priority over accept and over out_ready.

Structure
REQ-030 Shared package adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default DATA_W/SLICE_W constants.
REQ-031 The per-cycle addition SHALL be one combinational sub-module, slice_adder (p/g generation, prefix carry, sum = p^carry, carry-out), instantiated once and shared across cycles.

Verification
REQ-032 Accept a=0x0000_0001, b=0x0000_0002, cin=0 -> out_valid rises 4 edges after the accept; sum=0x0000_0003, cout=0, ovf=0.
REQ-033 Accept a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0 (carry ripples through all 4 slices).
REQ-034 Accept a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1; a=0x8000_0000 plus b=0x8000_0000 -> sum=0, cout=1, ovf=1.
REQ-035 Hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 throughout -> result stable, in_ready=0, no second accept; when out_ready=1, IDLE follows, then the next accept.
REQ-036 Assert rst on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; a fresh operation of 5+6 then yields 11 after 4 edges.
REQ-037 Apply 10,000 random a/b/cin operations with random out_ready stalls -> every sum, cout and ovf matches a DATA_W+1-bit reference model.
